obstacle_lane: RTL

Single follower obstacle (one car lane) for the scrolling road. Consumes the `move_followers` pulse from the vertical scroll stage to slide the car down the screen in lock-step with the road. Moves the car horizontally on its own timebase and respawns it at the top with LFSR-chosen position, direction and speed when it scrolls off the bottom. Reports a registered player/car overlap (`hit`) to the game-state logic; several instances with different `INIT_Y`/`SEED` form the obstacle field.

---
 rtl/obstacle_lane.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/obstacle_lane.sv
// rtl/obstacle_lane.sv - single scrolling obstacle car lane with LFSR respawn and player hit flag
module obstacle_lane #(
    parameter int          INIT_X        = 304,
    parameter int          INIT_Y        = 0,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          MOVE_AMT      = 2,
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          CAR_W         = 32,
    parameter int          CAR_H         = 16,
    parameter int          PLAYER_W      = 16,
    parameter int          PLAYER_H      = 16,
    parameter int          X_PERIOD      = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_followers,
    input  logic       enable,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] car_x,
    output logic [9:0] car_y,
    output logic       car_dir,
    output logic [1:0] car_speed,
    output logic       respawn,
    output logic       hit
);

    // An all-zero seed would lock the Galois LFSR at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam int             TW        = (X_PERIOD > 1) ? $clog2(X_PERIOD) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(X_PERIOD - 1);

    localparam logic [10:0] W11   = 11'(SCREEN_WIDTH);
    localparam logic [10:0] H11   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] MA11  = 11'(MOVE_AMT);
    localparam logic [10:0] CW11  = 11'(CAR_W);
    localparam logic [10:0] CH11  = 11'(CAR_H);
    localparam logic [10:0] PW11  = 11'(PLAYER_W);
    localparam logic [10:0] PH11  = 11'(PLAYER_H);
    localparam logic [9:0]  INIT_X10 = 10'(INIT_X);
    localparam logic [9:0]  INIT_Y10 = 10'(INIT_Y);

    logic [15:0]   lfsr_q,    lfsr_d;
    logic [TW-1:0] tick_q,    tick_d;
    logic [9:0]    car_x_q,   car_x_d;
    logic [9:0]    car_y_q,   car_y_d;
    logic          car_dir_q, car_dir_d;
    logic [1:0]    speed_q,   speed_d;
    logic          respawn_q, respawn_d;
    logic          hit_q,     hit_d;

    logic          step;
    logic          wrap_y;
    logic [10:0]   y_sum;
    logic [10:0]   right_sum;
    logic [10:0]   x_right;
    logic [10:0]   x_left;
    logic [10:0]   x_stepped;
    logic [1:0]    lfsr_speed;

    // Free-running Galois LFSR, independent of every input.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Horizontal timebase: counts enabled cycles, wraps after X_PERIOD of them.
    always_comb begin
        step   = enable && (tick_q == TICK_LAST);
        tick_d = tick_q;
        if (enable) begin
            tick_d = step ? '0 : tick_q + TW'(1);
        end
    end

    // Candidate next x for a horizontal step, wrapping at the screen edges.
    always_comb begin
        right_sum = {1'b0, car_x_q} + {9'b0, speed_q};
        x_right   = (right_sum >= W11) ? right_sum - W11 : right_sum;
        if (car_x_q < {8'b0, speed_q}) begin
            x_left = {1'b0, car_x_q} + W11 - {9'b0, speed_q};
        end else begin
            x_left = {1'b0, car_x_q} - {9'b0, speed_q};
        end
        x_stepped = car_dir_q ? x_left : x_right;
    end

    // Position update: a respawn overrides any step landing in the same cycle.
    always_comb begin
        y_sum      = {1'b0, car_y_q} + MA11;
        wrap_y     = move_followers && (y_sum >= H11);
        lfsr_speed = (lfsr_q[11:10] == 2'd0) ? 2'd1 : lfsr_q[11:10];

        car_x_d   = car_x_q;
        car_y_d   = car_y_q;
        car_dir_d = car_dir_q;
        speed_d   = speed_q;
        respawn_d = 1'b0;

        if (step) begin
            car_x_d = x_stepped[9:0];
        end

        if (wrap_y) begin
            car_y_d   = 10'd0;
            respawn_d = 1'b1;
            car_x_d   = {1'b0, lfsr_q[8:0]};
            car_dir_d = lfsr_q[9];
            speed_d   = lfsr_speed;
        end else if (move_followers) begin
            car_y_d = y_sum[9:0];
        end
    end

    // Box overlap of the registered car against the live player position.
    always_comb begin
        hit_d = ({1'b0, player_x} < {1'b0, car_x_q} + CW11) &&
                ({1'b0, car_x_q}  < {1'b0, player_x} + PW11) &&
                ({1'b0, player_y} < {1'b0, car_y_q} + CH11) &&
                ({1'b0, car_y_q}  < {1'b0, player_y} + PH11);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q    <= SEED_EFF;
            tick_q    <= '0;
            car_x_q   <= INIT_X10;
            car_y_q   <= INIT_Y10;
            car_dir_q <= 1'b0;
            speed_q   <= 2'd1;
            respawn_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            tick_q    <= tick_d;
            car_x_q   <= car_x_d;
            car_y_q   <= car_y_d;
            car_dir_q <= car_dir_d;
            speed_q   <= speed_d;
            respawn_q <= respawn_d;
            hit_q     <= hit_d;
        end
    end

    assign car_x     = car_x_q;
    assign car_y     = car_y_q;
    assign car_dir   = car_dir_q;
    assign car_speed = speed_q;
    assign respawn   = respawn_q;
    assign hit       = hit_q;

endmodule
